// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: FSM states, directions and PS/2 make codes.
// Pure definitions, no logic; also imported by the position datapath.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_P     = 8'h4D;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam int CNT_W = 4;

    // Encodings pair up so that flipping bit 0 gives the reverse heading.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    function automatic logic is_arrow(input logic [7:0] code);
        return (code == KEY_UP) || (code == KEY_DOWN) ||
               (code == KEY_LEFT) || (code == KEY_RIGHT);
    endfunction

    function automatic dir_t key_to_dir(input logic [7:0] code);
        dir_t d;
        d = DIR_RIGHT;
        case (code)
            KEY_UP:   d = DIR_UP;
            KEY_DOWN: d = DIR_DOWN;
            KEY_LEFT: d = DIR_LEFT;
            default:  d = DIR_RIGHT;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/snake_move_timer.sv
// Frame-tick divider; step is a combinational strobe on the terminal tick (registered by the caller).
// Optional SNAKE_SPEEDUP_EN shortens the reload every GROWS_PER_LEVEL grow pulses; no backpressure.
module snake_move_timer
    import snake_pkg::*;
#(
    parameter int TICKS_PER_MOVE  = 4,
    parameter int MIN_TICKS       = 1,
    parameter int GROWS_PER_LEVEL = 4
) (
    input  logic clk25,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic frame_tick,
    input  logic grow,
    output logic step
);

    localparam logic [CNT_W-1:0] RELOAD_INIT = CNT_W'(TICKS_PER_MOVE);

    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] reload;

    // >= rather than == so a reload that shrank below the count still terminates.
    assign step = enable && frame_tick && (tick_cnt >= (reload - CNT_W'(1)));

    always_ff @(posedge clk25) begin
        if (rst || clear) begin
            tick_cnt <= '0;
        end else if (enable && frame_tick) begin
            tick_cnt <= step ? '0 : tick_cnt + CNT_W'(1);
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    localparam int GW = (GROWS_PER_LEVEL > 1) ? $clog2(GROWS_PER_LEVEL) : 1;
    localparam logic [GW-1:0]    GROW_LAST  = GW'(GROWS_PER_LEVEL - 1);
    localparam logic [CNT_W-1:0] RELOAD_MIN = CNT_W'(MIN_TICKS);

    logic [GW-1:0] grow_cnt;

    always_ff @(posedge clk25) begin
        if (rst || clear) begin
            reload   <= RELOAD_INIT;
            grow_cnt <= '0;
        end else if (enable && grow) begin
            if (grow_cnt == GROW_LAST) begin
                grow_cnt <= '0;
                if (reload > RELOAD_MIN) begin
                    reload <= reload - CNT_W'(1);
                end
            end else begin
                grow_cnt <= grow_cnt + GW'(1);
            end
        end
    end
`else
    localparam int unused_cfg = MIN_TICKS + GROWS_PER_LEVEL;
    logic unused_grow;

    assign reload      = RELOAD_INIT;
    assign unused_grow = grow;
`endif

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game FSM (IDLE/RUN/PAUSE/DEAD), direction latch and move strobe; SNAKE_SPEEDUP_EN enables speed-up.
// All outputs registered, step 1 cycle after terminal frame_tick; pulse inputs, no backpressure.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICKS_PER_MOVE  = 4,
    parameter int MIN_TICKS       = 1,
    parameter int GROWS_PER_LEVEL = 4
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       frame_tick,
    input  logic       died,
    input  logic       grow,
    output logic       step,
    output logic [1:0] dir,
    output logic       init_snake,
    output logic       screen_black,
    output logic       screen_pause,
    output logic [1:0] state_dbg
);

    state_t state_q;
    state_t state_d;
    dir_t   dir_q;
    dir_t   pend_q;

    logic key_esc;
    logic key_space;
    logic key_p;
    logic start;
    logic run_en;
    logic fire;
    logic commit;
    logic arrow_ok;
    dir_t arrow_dir;

    assign key_esc   = key_valid && (key_code == KEY_ESC);
    assign key_space = key_valid && (key_code == KEY_SPACE);
    assign key_p     = key_valid && (key_code == KEY_P);

    always_comb begin
        state_d = state_q;
        if (key_esc) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (key_space) state_d = ST_RUN;
                ST_RUN: begin
                    if (died)       state_d = ST_DEAD;
                    else if (key_p) state_d = ST_PAUSE;
                end
                ST_PAUSE: if (key_p) state_d = ST_RUN;
                ST_DEAD:  if (key_space) state_d = ST_IDLE;
            endcase
        end
    end

    assign start  = (state_q == ST_IDLE) && (state_d == ST_RUN);
    // died and ESC both pre-empt a terminal tick, so they gate the divider outright.
    assign run_en = (state_q == ST_RUN) && !key_esc && !died;

    snake_move_timer #(
        .TICKS_PER_MOVE  (TICKS_PER_MOVE),
        .MIN_TICKS       (MIN_TICKS),
        .GROWS_PER_LEVEL (GROWS_PER_LEVEL)
    ) u_timer (
        .clk25      (clk25),
        .rst        (rst),
        .enable     (run_en),
        .clear      (start),
        .frame_tick (frame_tick),
        .grow       (grow),
        .step       (fire)
    );

    assign commit    = fire && !step;
    assign arrow_dir = key_to_dir(key_code);
    assign arrow_ok  = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && !key_esc &&
                       key_valid && is_arrow(key_code) && (arrow_dir != opposite(dir_q));

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_RIGHT;
            pend_q       <= DIR_RIGHT;
            step         <= 1'b0;
            init_snake   <= 1'b1;
            screen_black <= 1'b1;
            screen_pause <= 1'b0;
        end else begin
            state_q      <= state_d;
            step         <= commit;
            init_snake   <= (state_d == ST_IDLE);
            screen_black <= (state_d == ST_IDLE);
            screen_pause <= (state_d == ST_PAUSE) || (state_d == ST_DEAD);
            if (start) begin
                dir_q  <= DIR_RIGHT;
                pend_q <= DIR_RIGHT;
            end else begin
                // Commit uses the pending value from before this edge's key.
                if (commit)   dir_q  <= pend_q;
                if (arrow_ok) pend_q <= arrow_dir;
            end
        end
    end

    assign dir       = dir_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios plus a randomized run against a game-rule model.
// Define SNAKE_SPEEDUP_EN for both bench and RTL to exercise the speed-up scenario.
module tb_snake_game_ctrl;

    localparam int TPM  = 4;
    localparam int MINT = 1;
    localparam int GPL  = 4;
`ifdef SNAKE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    localparam logic [7:0] K_SPACE = 8'h29, K_P = 8'h4D, K_ESC = 8'h76;
    localparam logic [7:0] K_UP = 8'h75, K_DOWN = 8'h72, K_LEFT = 8'h6B, K_RIGHT = 8'h74;

    logic       clk25 = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       frame_tick = 1'b0;
    logic       died = 1'b0;
    logic       grow = 1'b0;
    logic       step;
    logic [1:0] dir;
    logic       init_snake;
    logic       screen_black;
    logic       screen_pause;
    logic [1:0] state_dbg;

    int checks = 0;
    int passes = 0;

    // Game model: state 0 idle, 1 run, 2 pause, 3 dead; headings 0 up, 1 down, 2 left, 3 right.
    int m_state, m_dir, m_pend, m_frames, m_reload, m_grows;
    bit m_step;

    always #20 clk25 = ~clk25;

    snake_game_ctrl #(
        .TICKS_PER_MOVE  (TPM),
        .MIN_TICKS       (MINT),
        .GROWS_PER_LEVEL (GPL)
    ) dut (
        .clk25        (clk25),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .frame_tick   (frame_tick),
        .died         (died),
        .grow         (grow),
        .step         (step),
        .dir          (dir),
        .init_snake   (init_snake),
        .screen_black (screen_black),
        .screen_pause (screen_pause),
        .state_dbg    (state_dbg)
    );

    task automatic model_reset();
        m_state = 0; m_dir = 3; m_pend = 3; m_frames = 0;
        m_reload = TPM; m_grows = 0; m_step = 1'b0;
    endtask

    task automatic model_update(input bit kv, input logic [7:0] kc, input bit ft, input bit di, input bit gr);
        int  ns, heading, old_dir;
        bit  moved;
        ns = m_state; moved = 1'b0; heading = -1; old_dir = m_dir;
        if (kv && kc == K_UP)    heading = 0;
        if (kv && kc == K_DOWN)  heading = 1;
        if (kv && kc == K_LEFT)  heading = 2;
        if (kv && kc == K_RIGHT) heading = 3;
        if (kv && kc == K_ESC) begin
            ns = 0;
        end else begin
            if (m_state == 0 && kv && kc == K_SPACE) begin
                ns = 1; m_frames = 0; m_dir = 3; m_pend = 3; m_reload = TPM; m_grows = 0;
            end else if (m_state == 1 && di) begin
                ns = 3;
            end else if (m_state == 1) begin
                if (ft) begin
                    m_frames = m_frames + 1;
                    if (m_frames >= m_reload) begin m_frames = 0; moved = 1'b1; end
                end
                if (gr && SPEEDUP) begin
                    m_grows = m_grows + 1;
                    if (m_grows == GPL) begin
                        m_grows = 0;
                        if (m_reload > MINT) m_reload = m_reload - 1;
                    end
                end
                if (kv && kc == K_P) ns = 2;
            end else if (m_state == 2 && kv && kc == K_P) begin
                ns = 1;
            end else if (m_state == 3 && kv && kc == K_SPACE) begin
                ns = 0;
            end
            if ((m_state == 1 || m_state == 2) && heading >= 0) begin
                if (moved && !m_step) m_dir = m_pend;
                // A reversal is judged against the heading the snake is actually moving in.
                if (heading != (old_dir ^ 1)) m_pend = heading;
            end else if (moved && !m_step) begin
                m_dir = m_pend;
            end
        end
        m_step  = moved && !m_step;
        m_state = ns;
    endtask

    task automatic drive(input bit kv, input logic [7:0] kc, input bit ft, input bit di, input bit gr);
        key_valid = kv; key_code = kc; frame_tick = ft; died = di; grow = gr;
        model_update(kv, kc, ft, di, gr);
        @(posedge clk25);
        #1;
        key_valid = 1'b0; key_code = 8'h00; frame_tick = 1'b0; died = 1'b0; grow = 1'b0;
    endtask

    task automatic do_reset(input bit ft);
        rst = 1'b1; frame_tick = ft;
        model_reset();
        @(posedge clk25);
        #1;
        rst = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else passes++;
        checks++; if (dir !== 2'd3) $display("FAIL reset_dir: got %0d want 3", dir); else passes++;
        checks++; if (step !== 1'b0) $display("FAIL reset_step: got %0b want 0", step); else passes++;
        checks++; if ({init_snake, screen_black, screen_pause} !== 3'b110)
            $display("FAIL reset_flags: got %b want 110", {init_snake, screen_black, screen_pause}); else passes++;
    endtask

    task automatic test_start_and_step();
        drive(1'b1, K_SPACE, 1'b0, 1'b0, 1'b0);
        checks++; if (state_dbg !== 2'd1) $display("FAIL start_state: got %0d want 1", state_dbg); else passes++;
        checks++; if ({init_snake, screen_black, screen_pause} !== 3'b000)
            $display("FAIL start_flags: got %b want 000", {init_snake, screen_black, screen_pause}); else passes++;
        for (int t = 1; t <= 4; t++) begin
            idle($urandom_range(0, 3));
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            checks++; if (step !== (t == 4)) $display("FAIL start_tick%0d_step: got %0b want %0b", t, step, t == 4); else passes++;
        end
        checks++; if (dir !== 2'd3) $display("FAIL start_step_dir: got %0d want 3", dir); else passes++;
        idle(1);
        checks++; if (step !== 1'b0) $display("FAIL start_step_width: got %0b want 0", step); else passes++;
    endtask

    task automatic test_direction();
        drive(1'b1, K_LEFT, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 4; t++) begin idle($urandom_range(1, 2)); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); end
        checks++; if (step !== 1'b1 || dir !== 2'd3) $display("FAIL dir_reverse_dropped: got step=%0b dir=%0d want step=1 dir=3", step, dir); else passes++;
        drive(1'b1, K_UP, 1'b0, 1'b0, 1'b0);
        idle($urandom_range(0, 3));
        drive(1'b1, K_DOWN, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 4; t++) begin idle($urandom_range(1, 2)); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); end
        checks++; if (step !== 1'b1 || dir !== 2'd1) $display("FAIL dir_last_key_wins: got step=%0b dir=%0d want step=1 dir=1", step, dir); else passes++;
    endtask

    task automatic test_pause();
        int steps_seen;
        for (int t = 1; t <= 2; t++) begin idle(1); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); end
        drive(1'b1, K_P, 1'b0, 1'b0, 1'b0);
        checks++; if (state_dbg !== 2'd2 || screen_pause !== 1'b1 || init_snake !== 1'b0)
            $display("FAIL pause_enter: got state=%0d pause=%0b init=%0b want 2/1/0", state_dbg, screen_pause, init_snake); else passes++;
        steps_seen = 0;
        for (int t = 1; t <= 5; t++) begin
            idle(1); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (step === 1'b1) steps_seen++;
        end
        checks++; if (steps_seen != 0) $display("FAIL pause_no_step: got %0d steps want 0", steps_seen); else passes++;
        drive(1'b1, K_P, 1'b0, 1'b0, 1'b0);
        checks++; if (state_dbg !== 2'd1) $display("FAIL pause_resume: got %0d want 1", state_dbg); else passes++;
        idle(1); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (step !== 1'b0) $display("FAIL resume_tick1: got %0b want 0", step); else passes++;
        idle(1); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (step !== 1'b1 || dir !== 2'd1) $display("FAIL resume_tick2: got step=%0b dir=%0d want 1/1", step, dir); else passes++;
    endtask

    task automatic test_died_terminal();
        for (int t = 1; t <= 3; t++) begin idle(1); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); end
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (step !== 1'b0) $display("FAIL died_no_step: got %0b want 0", step); else passes++;
        checks++; if (state_dbg !== 2'd3 || screen_pause !== 1'b1 || screen_black !== 1'b0)
            $display("FAIL died_state: got state=%0d pause=%0b black=%0b want 3/1/0", state_dbg, screen_pause, screen_black); else passes++;
        idle(1);
        checks++; if (step !== 1'b0) $display("FAIL died_no_late_step: got %0b want 0", step); else passes++;
        drive(1'b1, K_SPACE, 1'b0, 1'b0, 1'b0);
        checks++; if (state_dbg !== 2'd0 || init_snake !== 1'b1 || screen_black !== 1'b1)
            $display("FAIL dead_to_idle: got state=%0d init=%0b black=%0b want 0/1/1", state_dbg, init_snake, screen_black); else passes++;
    endtask

    task automatic test_esc_and_rst();
        drive(1'b1, K_SPACE, 1'b0, 1'b0, 1'b0);
        drive(1'b1, K_UP, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 4; t++) begin idle(1); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); end
        checks++; if (step !== 1'b1 || dir !== 2'd0) $display("FAIL esc_pre_step: got step=%0b dir=%0d want 1/0", step, dir); else passes++;
        drive(1'b1, K_P, 1'b0, 1'b0, 1'b0);
        drive(1'b1, K_LEFT, 1'b0, 1'b0, 1'b0);
        drive(1'b1, K_ESC, 1'b1, 1'b1, 1'b0);
        checks++; if ({state_dbg, init_snake, screen_black, screen_pause} !== 5'b00110)
            $display("FAIL esc_from_pause: got %b want 00110", {state_dbg, init_snake, screen_black, screen_pause}); else passes++;
        drive(1'b1, K_SPACE, 1'b0, 1'b0, 1'b0);
        checks++; if (dir !== 2'd3) $display("FAIL esc_restart_dir: got %0d want 3", dir); else passes++;
        for (int t = 1; t <= 3; t++) begin idle(1); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); end
        do_reset(1'b1);
        checks++; if ({step, dir, state_dbg, init_snake, screen_black, screen_pause} !== 8'b0_11_00_110)
            $display("FAIL rst_in_run: got %b want 01100110", {step, dir, state_dbg, init_snake, screen_black, screen_pause}); else passes++;
    endtask

`ifdef SNAKE_SPEEDUP_EN
    task automatic measure_move(input int want, input string name);
        int n;
        n = 0;
        while (n < 20) begin
            idle(1); drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n++;
            if (step === 1'b1) break;
        end
        checks++; if (n != want) $display("FAIL %s: got %0d frames per move want %0d", name, n, want); else passes++;
    endtask

    task automatic test_speedup();
        drive(1'b1, K_SPACE, 1'b0, 1'b0, 1'b0);
        measure_move(4, "speed_level0");
        for (int g = 0; g < 4; g++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        measure_move(3, "speed_level1");
        for (int g = 0; g < 4; g++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        measure_move(2, "speed_level2");
        for (int g = 0; g < 4; g++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        measure_move(1, "speed_level3");
        for (int g = 0; g < 4; g++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        measure_move(1, "speed_saturated");
        drive(1'b1, K_ESC, 1'b0, 1'b0, 1'b0);
        drive(1'b1, K_SPACE, 1'b0, 1'b0, 1'b0);
        measure_move(4, "speed_restored");
    endtask
`endif

    task automatic test_random();
        logic [7:0] kc;
        bit kv, ft, di, gr, last_ft;
        int r, bad;
        logic [7:0] got, want;
        bad = 0; last_ft = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 999) < 4) begin
                do_reset($urandom_range(0, 1) == 1);
                last_ft = 1'b0;
            end else begin
                kv = ($urandom_range(0, 99) < 12);
                r  = $urandom_range(0, 99);
                if (r < 3)       kc = K_ESC;
                else if (r < 20) kc = K_SPACE;
                else if (r < 30) kc = K_P;
                else if (r < 40) kc = 8'h1C;
                else if (r < 55) kc = K_UP;
                else if (r < 70) kc = K_DOWN;
                else if (r < 85) kc = K_LEFT;
                else             kc = K_RIGHT;
                ft = !last_ft && ($urandom_range(0, 99) < 35);
                di = ($urandom_range(0, 999) < 8);
                gr = ($urandom_range(0, 99) < 6);
                drive(kv, kc, ft, di, gr);
                last_ft = ft;
            end
            got  = {step, dir, state_dbg, init_snake, screen_black, screen_pause};
            want = {m_step, 2'(m_dir), 2'(m_state), m_state == 0, m_state == 0, m_state >= 2};
            checks++;
            if (got !== want) begin
                if (bad < 10) $display("FAIL random_cycle%0d: got %b want %b (step,dir,state,init,black,pause)", c, got, want);
                bad++;
            end else begin
                passes++;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        idle(2);
        test_reset();
        test_start_and_step();
        test_direction();
        test_pause();
        test_died_terminal();
        test_esc_and_rst();
`ifdef SNAKE_SPEEDUP_EN
        test_speedup();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game-level controller that sequences the snake position datapath. It runs the IDLE/RUN/PAUSE/DEAD state machine and latches arrow-key direction requests, blocking 180-degree reversals. It divides frame ticks into single-cycle move strobes and drives the screen control flags (init_snake, screen_black, screen_pause) consumed by the pixel and position logic. It sits between the PS/2 decoder, the collision checker and the segment-shift datapath, all in the clk25 domain.

Parameters:
TICKS_PER_MOVE, 4, frames between move strobes at base speed (1..15)
MIN_TICKS, 1, fastest allowed frames per move (SNAKE_SPEEDUP_EN only)
GROWS_PER_LEVEL, 4, grow events per speed-up (SNAKE_SPEEDUP_EN only)

Ports:
clk25  in  1  system pixel clock
rst  in  1  synchronous reset, active-high
key_valid  in  1  one-cycle pulse, key_code valid (already synchronised to clk25)
key_code  in  8  PS/2 make code
frame_tick  in  1  one-cycle pulse per frame (start of vertical sync)
died  in  1  one-cycle pulse from collision checker
grow  in  1  one-cycle pulse when food eaten (ignored without SNAKE_SPEEDUP_EN)
step  out  1  one-cycle move strobe to position datapath
dir  out  2  committed direction, valid when step=1: UP=0, DOWN=1, LEFT=2, RIGHT=3
init_snake  out  1  load initial segment positions
screen_black  out  1  blank display
screen_pause  out  1  freeze display (snake drawn, no motion)
state_dbg  out  2  current state encoding

Behaviour:
- All outputs registered. Reset (sync, rst=1 at clk25 edge):
  - state=IDLE, dir=RIGHT, pending_dir=RIGHT, tick_cnt=0, step=0.
  - init_snake=1, screen_black=1, screen_pause=0.
- State encoding: IDLE=0, RUN=1, PAUSE=2, DEAD=3.
- Key codes: SPACE=0x29, P=0x4D, ESC=0x76, UP=0x75, DOWN=0x72, LEFT=0x6B, RIGHT=0x74.
- Key codes are acted on only when key_valid=1. Any other code is ignored.
- Transitions:
  - ESC from any state -> IDLE.
  - IDLE + SPACE -> RUN. tick_cnt cleared; dir and pending_dir reset to RIGHT.
  - RUN + P -> PAUSE. PAUSE + P -> RUN.
  - RUN + died -> DEAD. died is ignored in every other state.
  - DEAD + SPACE -> IDLE.
- Output flags by state:
  - IDLE: init_snake=1, screen_black=1, screen_pause=0.
  - RUN: all three flags 0.
  - PAUSE and DEAD: init_snake=0, screen_black=0, screen_pause=1.
- Flags take their new-state values in the cycle after the transition edge.
- Direction handling:
  - An arrow key in RUN or PAUSE sets pending_dir, unless the key is the opposite of the committed dir (opposite = dir XOR 1); opposite keys are dropped.
  - The last accepted key before a step wins.
- Tick divider, RUN only:
  - On frame_tick, if tick_cnt==reload-1: tick_cnt<=0 and step=1 in the next cycle, with dir<=pending_dir in that same cycle.
  - Otherwise tick_cnt increments.
  - Latency from frame_tick to step is exactly 1 cycle.
- In PAUSE, DEAD and IDLE, frame_tick is ignored and tick_cnt is held. Resuming from PAUSE continues the count.
- Simultaneous events:
  - died together with a terminal frame_tick: died wins and no step is issued.
  - ESC together with any other event: ESC wins.
  - rst overrides everything, including mid-step; step is 0 in the cycle after reset.
- step is never high for two consecutive cycles.
- Without SNAKE_SPEEDUP_EN: reload = TICKS_PER_MOVE.

Optional Feature:
SNAKE_SPEEDUP_EN
- Defined:
  - grow pulses in RUN increment grow_cnt (width clog2(GROWS_PER_LEVEL)).
  - On reaching GROWS_PER_LEVEL, grow_cnt wraps to 0 and reload decrements, saturating at MIN_TICKS.
  - reload returns to TICKS_PER_MOVE on entry to RUN from IDLE and on reset.
  - A reload change applies from the next divider comparison; if tick_cnt already exceeds reload-1, the next frame_tick treats it as terminal.
- Undefined: grow port is present but unused; reload is constant.

Decomposition:
- Package snake_pkg holds:
  - state encodings;
  - direction encodings and the opposite rule;
  - PS/2 key code constants (also reused by the position datapath).
- One sub-module, snake_move_timer: frame_tick divider plus speed-up reload logic. Ports: enable, clear, frame_tick, grow, step.

Test Plan:
- Reset, then SPACE -> state RUN next cycle, flags 0/0/0; with TICKS_PER_MOVE=4, frame_ticks 1-4 give exactly one step, 1 cycle after the 4th tick, dir=3.
- In RUN with dir=RIGHT: LEFT key -> dropped; UP then DOWN before a step -> next step has dir=1 (DOWN accepted while committed dir is still RIGHT).
- In RUN: P after 2 ticks, 5 frame_ticks, P again -> no step while paused; 2 further ticks after resume produce a step.
- died on the same cycle as the terminal frame_tick -> no step, state DEAD, screen_pause=1; SPACE -> IDLE with init_snake=1 and screen_black=1.
- ESC in PAUSE together with an arrow key -> IDLE, dir reset to RIGHT on the next SPACE; rst asserted in RUN -> all outputs at reset values the next cycle.
- SNAKE_SPEEDUP_EN: 12 grow pulses -> reload goes 4 to 3 to 2 to 1, saturating at MIN_TICKS=1 (one step per frame_tick); return to IDLE then SPACE -> reload back to 4.
